// File: rtl/feature_stream_buffer.sv
// feature_stream_buffer
//   Show-ahead FIFO between the first-block conv/BN stage and the next layer.
//   Data words (Q8.8) pass through unmodified. The output side tags each word
//   with its (row, col, channel) position in the feature map. It also flags
//   the final word of a frame and pulses done once the frame has been consumed.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous reset, active low
//   en           write enable (the read side drains regardless)
//   data_in      upstream data word
//   valid_in     data_in qualifier
//   channel_in   upstream channel tag, compared against the expected sequence
//   in_ready     almost-full backpressure to upstream
//   data_out     FIFO head (0 while empty)
//   valid_out    FIFO non-empty
//   ready_in     downstream accept
//   channel_out  position of data_out: channel
//   col_out      position of data_out: column
//   row_out      position of data_out: row
//   last_out     data_out is the last element of the frame
//   done         one-cycle pulse after the last element is transferred
//   level        current occupancy
//   overflow     sticky: a write was attempted while full
//   ch_err       sticky: an accepted word carried an unexpected channel tag
module feature_stream_buffer #(
   parameter int N            = 16,
   parameter int FEATURE_SIZE = 112,
   parameter int CHANNELS     = 16,
   parameter int DEPTH        = 64,
   parameter int AFULL_MARGIN = 4,
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int PW = (FEATURE_SIZE > 1) ? $clog2(FEATURE_SIZE) : 1,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [N-1:0]  data_in,
   input  logic          valid_in,
   input  logic [CW-1:0] channel_in,
   output logic          in_ready,
   output logic [N-1:0]  data_out,
   output logic          valid_out,
   input  logic          ready_in,
   output logic [CW-1:0] channel_out,
   output logic [PW-1:0] col_out,
   output logic [PW-1:0] row_out,
   output logic          last_out,
   output logic          done,
   output logic [LW-1:0] level,
   output logic          overflow,
   output logic          ch_err
);

   localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
   localparam logic [LW-1:0] AFULL_LVL = LW'(DEPTH - AFULL_MARGIN);
   localparam logic [CW-1:0] CH_MAX    = CW'(CHANNELS - 1);
   localparam logic [PW-1:0] POS_MAX   = PW'(FEATURE_SIZE - 1);

   logic [N-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] exp_ch;
   logic          full;
   logic          wr_en;
   logic          rd_en;
   logic          ch_last;
   logic          col_last;
   logic          row_last;

   // Full blocks the write even when a read frees a slot in the same cycle.
   assign full      = (level == FULL_LVL);
   assign wr_en     = en && valid_in && !full;
   assign valid_out = (level != '0);
   assign rd_en     = valid_out && ready_in;
   assign in_ready  = en && (level < AFULL_LVL);
   assign data_out  = valid_out ? mem[rd_ptr] : '0;

   assign ch_last   = (channel_out == CH_MAX);
   assign col_last  = (col_out == POS_MAX);
   assign row_last  = (row_out == POS_MAX);
   assign last_out  = valid_out && ch_last && col_last && row_last;

   // Storage carries no reset; only entries between rd_ptr and wr_ptr are visible.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         exp_ch      <= '0;
         channel_out <= '0;
         col_out     <= '0;
         row_out     <= '0;
         done        <= 1'b0;
         overflow    <= 1'b0;
         ch_err      <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);

         case ({wr_en, rd_en})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase

         if (en && valid_in && full) overflow <= 1'b1;

         // Expected channel follows its own sequence, so one bad tag is
         // reported once rather than shifting every later comparison.
         if (wr_en) begin
            if (channel_in != exp_ch) ch_err <= 1'b1;
            exp_ch <= (exp_ch == CH_MAX) ? '0 : exp_ch + CW'(1);
         end

         if (rd_en) begin
            if (ch_last) begin
               channel_out <= '0;
               if (col_last) begin
                  col_out <= '0;
                  row_out <= row_last ? '0 : row_out + PW'(1);
               end else begin
                  col_out <= col_out + PW'(1);
               end
            end else begin
               channel_out <= channel_out + CW'(1);
            end
         end

         done <= rd_en && last_out;
      end
   end

endmodule

// File: doc/feature_stream_buffer.md
FEATURE_STREAM_BUFFER -- requirements
Module: feature_stream_buffer

Interface
REQ-001 Parameter N, default 16, data width (Q8.8 fixed point, passed through unmodified).
REQ-002 Parameter FEATURE_SIZE, default 112, output feature map width and height.
REQ-003 Parameter CHANNELS, default 16, channels per pixel, channel-sequential order.
REQ-004 Parameter DEPTH, default 64, FIFO entries, power of two, at least 8.
REQ-005 Parameter AFULL_MARGIN, default 4, in_ready deasserts when level >= DEPTH-AFULL_MARGIN.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  synchronous, active-low reset.
REQ-008 en  in  1  write enable; output side drains regardless of en.
REQ-009 data_in  in  N  conv/BN result from the upstream first-block stage.
REQ-010 valid_in  in  1  data_in qualifier.
REQ-011 channel_in  in  clog2(CHANNELS)  upstream channel tag of data_in.
REQ-012 in_ready  out  1  almost-full backpressure to upstream.
REQ-013 data_out  out  N  FIFO head.
REQ-014 valid_out  out  1  data_out valid.
REQ-015 ready_in  in  1  downstream accept.
REQ-016 channel_out / col_out / row_out  out  clog2(CHANNELS) / clog2(FEATURE_SIZE) / clog2(FEATURE_SIZE)  position of data_out.
REQ-017 last_out  out  1  data_out is final element of frame.
REQ-018 done  out  1  one-cycle frame-complete pulse.
REQ-019 level  out  clog2(DEPTH)+1  current occupancy.
REQ-020 overflow / ch_err  out  1 each  sticky error flags.

Function
REQ-021 Write occurs when en && valid_in && level < DEPTH; full blocks a write even if a read happens in the same cycle.
REQ-022 valid_in while level == DEPTH with en=1 drops the word and sets overflow; no FIFO state changes.
REQ-023 Show-ahead FIFO: a word written into an empty FIFO at edge t appears with valid_out=1 after edge t (visible in cycle t+1); no fall-through in cycle t.
REQ-024 Transfer = valid_out && ready_in; the head advances at that edge; data_out and position outputs hold stable while valid_out && !ready_in.
REQ-025 Simultaneous write and transfer with 0 < level < DEPTH leaves level unchanged.
REQ-026 in_ready = en && (level < DEPTH-AFULL_MARGIN), combinational from registered level.
REQ-027 Output position counters advance on each transfer: channel_out 0..CHANNELS-1, then col_out increments, then row_out; all wrap to 0 after (FEATURE_SIZE-1, FEATURE_SIZE-1, CHANNELS-1).
REQ-028 last_out = valid_out && all three counters at their maxima.
REQ-029 done pulses high exactly one cycle, in the cycle after the transfer with last_out=1; the next frame starts at position (0,0,0) with no gap required.
REQ-030 An input-side expected-channel counter advances on each accepted write and wraps at CHANNELS; an accepted write whose channel_in differs from it sets ch_err; the word is still stored, and the counter advances from the expected value, not from channel_in.
REQ-031 Read and write pointers are clog2(DEPTH) bits and wrap naturally; level is computed with one extra bit so full and empty are distinct.
REQ-032 en=0 blocks writes only; overflow is not set by valid_in while en=0.

Reset
REQ-033 While rst=0 at a rising edge: pointers, level, all position counters, and expected-channel counter reset to 0; valid_out, done, last_out, overflow, and ch_err reset to 0; data_out resets to 0.
REQ-034 Reset mid-frame discards all FIFO contents and position state; the first accepted word after release is (row 0, col 0, ch 0).
REQ-035 Sticky flags clear only by reset.

Verification
REQ-036 Single word: after reset, en=1, one write of 16'h0180 with ch 0 -> next cycle valid_out=1, data_out=0180, position (0,0,0), level=1; ready_in=1 -> level=0 on following edge.
REQ-037 Backpressure: ready_in=0, 60 writes -> in_ready=0 once level=60; 4 more writes -> level=64; 65th write -> overflow=1, level stays 64, head data unchanged.
REQ-038 Full frame: 200704 words, channels 0..15 cycling, ready_in randomly toggled -> 200704 transfers in order, last_out only on final transfer at (111,111,15), done exactly one pulse, counters read (0,0,0) afterward.
REQ-039 Channel error: write sequence with channel tags 0,1,3 -> ch_err=1 on the third write's edge; all three words emerge with channel_out 0,1,2.
REQ-040 Reset mid-frame: rst=0 for one cycle after 5000 transfers -> level=0, valid_out=0, flags 0; next frame produces position (0,0,0) first and done after 200704 further transfers.
REQ-041 Simultaneous: level=64 with ready_in=1 and valid_in=1 -> write dropped, overflow=1, level=63.
